svm_score_accumulator: RTL and testbench
========================================

SVM_SCORE_ACCUMULATOR -- requirements
Module: svm_score_accumulator

Interface
REQ-001 The block SHALL have parameter SUM_WIDTH, default 16, giving the width of each incoming partial sum (unsigned).
REQ-002 The block SHALL have parameter CHUNK_COUNT, default 8, giving the number of partial sums per score (legal range 1..256).
REQ-003 The block SHALL derive localparam ACC_WIDTH = SUM_WIDTH + clog2(CHUNK_COUNT), with a minimum of SUM_WIDTH when CHUNK_COUNT=1.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1 bit: synchronous active-high reset.
REQ-007 Port in_valid, input, 1 bit: in_sum holds a valid partial sum.
REQ-008 Port in_ready, output, 1 bit: the block can accept a partial sum this cycle.
REQ-009 Port in_sum, input, SUM_WIDTH bits: unsigned partial sum produced by the upstream multi-operand adder.
REQ-010 Port threshold, input, ACC_WIDTH bits: unsigned decision threshold.
REQ-011 Port out_valid, output, 1 bit: out_score and out_class are valid.
REQ-012 Port out_ready, input, 1 bit: the downstream stage accepts the result.
REQ-013 Port out_score, output, ACC_WIDTH bits: the total of CHUNK_COUNT partial sums.
REQ-014 Port out_class, output, 1 bit: 1 when out_score > threshold, else 0.

Function
REQ-015 The block SHALL implement two states: ACCUM (collecting chunks) and HOLD (presenting a result).
REQ-016 In ACCUM, in_ready SHALL be 1 and out_valid SHALL be 0; in HOLD, in_ready SHALL be 0 and out_valid SHALL be 1.
REQ-017 A chunk is accepted when in_valid && in_ready on a rising edge; on acceptance the accumulator SHALL add zero-extended in_sum and the chunk counter SHALL increment.
REQ-018 When the accepted chunk is number CHUNK_COUNT, the block SHALL load out_score = accumulator + in_sum and out_class = (that value > threshold), with threshold sampled on that edge; it SHALL then enter HOLD.
REQ-019 Latency SHALL be exactly one cycle: out_valid rises in the cycle after the final chunk is accepted.
REQ-020 Arithmetic SHALL never overflow because ACC_WIDTH guarantees CHUNK_COUNT*(2^SUM_WIDTH-1) fits; no saturation or wrap logic is required.
REQ-021 While in HOLD with out_ready=0, out_score and out_class SHALL remain stable, and in_sum/threshold changes SHALL have no effect.
REQ-022 When out_valid && out_ready, the block SHALL clear the accumulator and counter and return to ACCUM; in_ready SHALL become 1 in the next cycle (one bubble per score).
REQ-023 With in_valid=0 in ACCUM, the accumulator and counter SHALL hold their values; gaps between chunks are allowed.
REQ-024 With CHUNK_COUNT=1, every accepted chunk SHALL directly produce a result (out_score = in_sum).
REQ-025 The equality case out_score == threshold SHALL give out_class=0.

Reset
REQ-026 On rst=1 at a rising edge, the state SHALL become ACCUM, the accumulator and counter 0, out_valid 0, out_score 0, out_class 0; in_ready SHALL be 1 in the following cycle.
REQ-027 A reset in the middle of a score, or during HOLD, SHALL discard the partial or pending result with no output handshake.
REQ-028 rst SHALL take priority over a simultaneous in or out handshake.

Verification (SUM_WIDTH=5, CHUNK_COUNT=4, ACC_WIDTH=7)
REQ-029 Send chunks 1,2,3,4 back-to-back with threshold=9 and out_ready=1 -> out_valid for one cycle, out_score=10, out_class=1, then in_ready=1 the next cycle.
REQ-030 Send 31,31,31,31 with threshold=124 -> out_score=124 (maximum, no overflow), out_class=0.
REQ-031 Send 2,0,2,0 with in_valid gaps of 3 idle cycles and threshold=3, holding out_ready=0 for 5 cycles -> out_score=4 and out_class=1 stay stable; in_ready stays 0 and new in_valid pulses are ignored until the handshake.
REQ-032 Send 7,7 then assert rst, then send 7,6,5,4 with threshold=30 -> the first partial score is discarded, out_score=22, out_class=0.
REQ-033 Send two consecutive scores (0,0,0,0 then 7,7,7,0) with threshold=0 -> results 0/class 0, then 21/class 1; the accumulator is cleared between scores.
REQ-034 The bench SHALL compare out_score against a reference sum of the accepted chunks on every output handshake and flag any mismatch.

Source files
------------

// File: rtl/svm_score_accumulator.sv
// Accumulates CHUNK_COUNT unsigned partial sums into one SVM score,
// then holds the score and its threshold decision until accepted.
module svm_score_accumulator #(
  parameter int SUM_WIDTH = 16,
  parameter int CHUNK_COUNT = 8,
  localparam int ACC_WIDTH = SUM_WIDTH + $clog2(CHUNK_COUNT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SUM_WIDTH-1:0] in_sum,
  input  logic [ACC_WIDTH-1:0] threshold,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_score,
  output logic                 out_class
);

  localparam int CNT_WIDTH = (CHUNK_COUNT > 1) ? $clog2(CHUNK_COUNT) : 1;
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(CHUNK_COUNT - 1);

  typedef enum logic {
    ACCUM,
    HOLD
  } state_t;

  state_t state;
  state_t state_next;

  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] sum;
  logic [CNT_WIDTH-1:0] cnt;
  logic accept;
  logic last;
  logic done;

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign last      = (cnt == LAST);
  assign done      = out_valid && out_ready;
  // ACC_WIDTH leaves room for CHUNK_COUNT full-scale chunks, so no wrap
  assign sum       = acc + ACC_WIDTH'(in_sum);

  always_comb begin
    state_next = state;
    unique case (state)
      ACCUM: if (accept && last) state_next = HOLD;
      HOLD:  if (done) state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      out_score <= '0;
      out_class <= 1'b0;
    end else if (done) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      if (last) begin
        out_score <= sum;
        out_class <= (sum > threshold);
      end else begin
        acc <= sum;
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_svm_score_accumulator.sv
// Scoreboard bench for svm_score_accumulator with 5-bit chunks, 4 per score.
module tb_svm_score_accumulator;

  localparam int SW = 5;
  localparam int CC = 4;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] in_sum;
  logic [AW-1:0] threshold;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_score;
  logic          out_class;

  int compared = 0;
  int mismatched = 0;

  logic [AW:0] exp_q[$];

  svm_score_accumulator #(
    .SUM_WIDTH(SW),
    .CHUNK_COUNT(CC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_sum(in_sum),
    .threshold(threshold),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_score(out_score),
    .out_class(out_class)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops one expected result per output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_output: score %0d class %0d", out_score, out_class);
      end else begin
        logic [AW:0] e;
        e = exp_q.pop_front();
        chk("out_score", int'(out_score), int'(e[AW:1]));
        chk("out_class", int'(out_class), int'(e[0]));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [SW-1:0] v);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_sum = v;
    while (!in_ready && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!in_ready) begin
      compared++;
      mismatched++;
      $display("FAIL send_timeout: in_ready %0d expected 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_result(input int score, input int cls);
    exp_q.push_back({AW'(score), cls[0]});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int t;
    rst = 1'b1;
    in_valid = 1'b0;
    in_sum = '0;
    threshold = '0;
    out_ready = 1'b1;
    cyc(2);
    rst = 1'b0;

    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_score", int'(out_score), 0);
    chk("rst_out_class", int'(out_class), 0);

    // 1+2+3+4 = 10 > 9
    threshold = 7'd9;
    expect_result(10, 1);
    send(5'd1);
    send(5'd2);
    send(5'd3);
    send(5'd4);
    chk("lat_out_valid", int'(out_valid), 1);
    chk("lat_in_ready", int'(in_ready), 0);
    cyc(1);
    chk("bubble_out_valid", int'(out_valid), 0);
    chk("bubble_in_ready", int'(in_ready), 1);

    // full scale: 124 == threshold -> class 0
    threshold = 7'd124;
    expect_result(124, 0);
    repeat (4) send(5'd31);
    cyc(1);

    // gaps plus downstream stall
    out_ready = 1'b0;
    threshold = 7'd3;
    expect_result(4, 1);
    send(5'd2);
    cyc(3);
    send(5'd0);
    cyc(3);
    send(5'd2);
    cyc(3);
    send(5'd0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_sum = 5'd31;
      threshold = 7'd100;
      chk("hold_in_ready", int'(in_ready), 0);
      chk("hold_out_valid", int'(out_valid), 1);
      chk("hold_out_score", int'(out_score), 4);
      chk("hold_out_class", int'(out_class), 1);
      cyc(1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc(1);

    // partial score discarded by reset
    threshold = 7'd30;
    send(5'd7);
    send(5'd7);
    do_reset();
    expect_result(22, 0);
    send(5'd7);
    send(5'd6);
    send(5'd5);
    send(5'd4);
    cyc(1);

    // pending result discarded by reset during HOLD
    out_ready = 1'b0;
    repeat (4) send(5'd9);
    chk("pend_out_valid", int'(out_valid), 1);
    do_reset();
    chk("hrst_out_valid", int'(out_valid), 0);
    chk("hrst_out_score", int'(out_score), 0);
    chk("hrst_in_ready", int'(in_ready), 1);
    out_ready = 1'b1;

    // back-to-back scores, accumulator cleared between
    threshold = 7'd0;
    expect_result(0, 0);
    repeat (4) send(5'd0);
    expect_result(21, 1);
    send(5'd7);
    send(5'd7);
    send(5'd7);
    send(5'd0);

    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      cyc(1);
      t++;
    end
    chk("queue_drained", exp_q.size(), 0);
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
